// File: rtl/pour_sequencer.sv
// Sequencer for the 4:1 liquid dispenser mux: accepts an order, settles the select lines, checks stock, pours, cools.
// Optional one-entry order buffer enabled by defining POUR_QUEUE_EN.
module pour_sequencer #(
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned BEER_CYC    = 8,
    parameter int unsigned WINE_CYC    = 4,
    parameter int unsigned RUM_CYC     = 2,
    parameter int unsigned WHISKEY_CYC = 2,
    parameter int unsigned COOL_CYC    = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       order_valid,
    input  logic [1:0] order_bev,
    output logic       order_ready,
    input  logic       cancel,
    input  logic       avail,
    output logic [1:0] select,
    output logic       pour_en,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       empty_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_POUR   = 2'd2;
    localparam logic [1:0] S_COOL   = 2'd3;

    // Counters hold "cycles remaining minus one", so expiry is cnt == 0.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOL_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       select_q, select_d;
    logic             pour_en_q, pour_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             empty_err_q, empty_err_d;
    logic             order_ready_q, order_ready_d;
    logic [CNT_W-1:0] pour_load;
    logic             accept;
`ifdef POUR_QUEUE_EN
    logic             queue_full_q, queue_full_d;
    logic [1:0]       queue_bev_q, queue_bev_d;
    logic             take_direct;
    logic             flush;
`endif

    assign accept = order_valid & order_ready_q;

    // Pour length for the beverage currently selected.
    always_comb begin
        case (select_q)
            2'b00:   pour_load = CNT_W'(BEER_CYC - 1);
            2'b01:   pour_load = CNT_W'(WINE_CYC - 1);
            2'b10:   pour_load = CNT_W'(RUM_CYC - 1);
            default: pour_load = CNT_W'(WHISKEY_CYC - 1);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        select_d    = select_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        empty_err_d = 1'b0;
`ifdef POUR_QUEUE_EN
        queue_full_d = queue_full_q;
        queue_bev_d  = queue_bev_q;
        take_direct  = 1'b0;
        flush        = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    select_d = order_bev;
                    cnt_d    = SETTLE_LOAD;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cancel) begin
                    state_d   = S_COOL;
                    cnt_d     = COOL_LOAD;
                    aborted_d = 1'b1;
`ifdef POUR_QUEUE_EN
                    flush     = 1'b1;
`endif
                end else if (cnt_q == '0) begin
                    if (avail) begin
                        state_d = S_POUR;
                        cnt_d   = pour_load;
                    end else begin
                        state_d     = S_COOL;
                        cnt_d       = COOL_LOAD;
                        empty_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_POUR: begin
                if (cancel) begin
                    state_d   = S_COOL;
                    cnt_d     = COOL_LOAD;
                    aborted_d = 1'b1;
`ifdef POUR_QUEUE_EN
                    flush     = 1'b1;
`endif
                end else if (!avail) begin
                    state_d     = S_COOL;
                    cnt_d       = COOL_LOAD;
                    empty_err_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_COOL;
                    cnt_d   = COOL_LOAD;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
`ifdef POUR_QUEUE_EN
                    // Queued order wins; otherwise an order arriving now bypasses the buffer.
                    if (queue_full_q) begin
                        state_d      = S_SETTLE;
                        select_d     = queue_bev_q;
                        cnt_d        = SETTLE_LOAD;
                        queue_full_d = 1'b0;
                    end else if (accept) begin
                        state_d     = S_SETTLE;
                        select_d    = order_bev;
                        cnt_d       = SETTLE_LOAD;
                        take_direct = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
`ifdef POUR_QUEUE_EN
        if (flush) begin
            queue_full_d = 1'b0;
        end else if (accept && (state_q != S_IDLE) && !take_direct) begin
            queue_full_d = 1'b1;
            queue_bev_d  = order_bev;
        end
`endif
        pour_en_d = (state_d == S_POUR);
        busy_d    = (state_d != S_IDLE);
`ifdef POUR_QUEUE_EN
        order_ready_d = !queue_full_d;
`else
        order_ready_d = (state_d == S_IDLE);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            select_q      <= 2'b00;
            pour_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            empty_err_q   <= 1'b0;
            order_ready_q <= 1'b1;
`ifdef POUR_QUEUE_EN
            queue_full_q  <= 1'b0;
            queue_bev_q   <= 2'b00;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            select_q      <= select_d;
            pour_en_q     <= pour_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            empty_err_q   <= empty_err_d;
            order_ready_q <= order_ready_d;
`ifdef POUR_QUEUE_EN
            queue_full_q  <= queue_full_d;
            queue_bev_q   <= queue_bev_d;
`endif
        end
    end

    assign order_ready = order_ready_q;
    assign select      = select_q;
    assign pour_en     = pour_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign empty_err   = empty_err_q;

endmodule

// File: doc/pour_sequencer.md
Name: pour_sequencer

Overview:
Sequential front end for the 4:1 liquid dispenser mux.
- Accepts a one-beverage order over a valid/ready handshake.
- Drives the mux select lines and lets them settle.
- Reads back the mux output `f` as tank-available, then gates the pour valve for a per-beverage cycle count.
- Enforces a cooldown before the next order.

Parameters:
SETTLE_CYC, 2, cycles select is held before avail is sampled (>=1)
BEER_CYC, 8, pour cycles for bev 00
WINE_CYC, 4, pour cycles for bev 01
RUM_CYC, 2, pour cycles for bev 10
WHISKEY_CYC, 2, pour cycles for bev 11
COOL_CYC, 3, cooldown cycles after any pour/abort (>=1)
CNT_W, 8, cycle counter width; every *_CYC must be < 2**CNT_W

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
order_valid  in  1  order present
order_bev  in  2  00 beer, 01 wine, 10 rum, 11 whiskey
order_ready  out  1  sequencer can accept an order this cycle
cancel  in  1  abort current order
avail  in  1  mux output f for the current select (1 = tank has stock)
select  out  2  to mux select inputs
pour_en  out  1  valve gate
busy  out  1  state != IDLE
done  out  1  1-cycle pulse, pour completed normally
aborted  out  1  1-cycle pulse, cancel honoured
empty_err  out  1  1-cycle pulse, avail low at sample point or during pour

Behaviour:
- Reset values:
  - State IDLE, counter 0.
  - select=00, pour_en=0, busy=0, done=0, aborted=0, empty_err=0.
  - order_ready=1.
  - A reset mid-pour drops pour_en at that same edge.
- States: IDLE, SETTLE, POUR, COOL.
- IDLE:
  - order_ready=1.
  - On an edge with order_valid&order_ready: latch order_bev into select, load counter, go to SETTLE.
  - order_bev is ignored when order_valid=0.
- SETTLE:
  - Lasts exactly SETTLE_CYC cycles; select is held.
  - avail is sampled on the last SETTLE cycle.
  - avail=1 -> POUR, counter loaded with the pour count for select.
  - avail=0 -> COOL; empty_err pulses in the first COOL cycle.
- POUR:
  - pour_en=1 for exactly the beverage's cycle count.
  - After the last pour cycle -> COOL; done pulses in the first COOL cycle.
  - avail=0 in any POUR cycle -> COOL next edge; pour_en=0 from that edge; empty_err pulse; no done.
- COOL:
  - Lasts exactly COOL_CYC cycles, pour_en=0, then -> IDLE.
- cancel:
  - Honoured only in SETTLE or POUR: -> COOL next edge, aborted pulse, pour_en=0 from that edge.
  - Ignored in IDLE and COOL.
- Priority in the same cycle: reset > cancel > avail-low > count expiry.
- Pulse exclusivity: done, aborted and empty_err are mutually exclusive; each is high for exactly one cycle.
- select holds its last value through COOL and IDLE until the next accepted order.
- order_ready=0 in all non-IDLE states, unless the queue option is enabled.
- Latency with defaults, order accepted at edge t0 (beer):
  - SETTLE: t1-t2.
  - pour_en: t3-t10.
  - done at t11.
  - COOL: t11-t13.
  - IDLE and order_ready=1 at t14.

Optional Feature:
POUR_QUEUE_EN
- Defined:
  - Adds a one-entry order buffer; order_ready = !queue_full in every state.
  - An order accepted while busy is stored.
  - On the last COOL cycle, a full queue moves straight to SETTLE with the queued bev, skipping IDLE; the queue empties on that edge.
  - Order accepted on the same edge as the last COOL cycle with the queue empty: taken directly into SETTLE, not stored.
  - cancel also flushes the queue.
  - reset empties the queue.
- Undefined:
  - No buffer; order_ready=1 only in IDLE.

Test Plan:
- reset, order bev=00, avail=1 -> pour_en high exactly 8 cycles (t3-t10), done at t11, order_ready back at t14, select=00 throughout.
- Orders 01, 10, 11 back-to-back, avail=1 -> pour_en widths 4, 2, 2; select 01, 10, 11; 3 idle-free COOL cycles between pours.
- bev=10 with avail=0 during SETTLE -> no pour_en, empty_err at t3, COOL t3-t5, IDLE at t6.
- bev=00; cancel at the 3rd POUR cycle together with avail=0 -> pour_en low next edge, aborted=1, empty_err=0, done never asserted.
- bev=00; reset asserted at the 5th POUR cycle -> next edge pour_en=0, busy=0, select=00, order_ready=1, no pulses.
- POUR_QUEUE_EN: bev=00 then bev=11 offered during POUR -> accepted; whiskey SETTLE starts at t14 with no IDLE cycle; order_ready=0 while queue full.
